// File: rtl/axis_2_ppfifo_pack_if.sv
// Signal bundle between an AXI-stream source, axis_2_ppfifo_pack and a ping-pong FIFO write port.
// The slave modport is the packer's view; the master modport is the stream/FIFO side.
interface axis_2_ppfifo_pack_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PACK       = 2
);
    logic                       i_axi_valid;
    logic                       o_axi_ready;
    logic [DATA_WIDTH-1:0]      i_axi_data;
    logic                       i_axi_last;
    logic [1:0]                 i_ppfifo_rdy;
    logic [1:0]                 o_ppfifo_act;
    logic [23:0]                i_ppfifo_size;
    logic                       o_ppfifo_stb;
    logic [DATA_WIDTH*PACK:0]   o_ppfifo_data;

    modport slave (
        input  i_axi_valid, i_axi_data, i_axi_last, i_ppfifo_rdy, i_ppfifo_size,
        output o_axi_ready, o_ppfifo_act, o_ppfifo_stb, o_ppfifo_data
    );

    modport master (
        output i_axi_valid, i_axi_data, i_axi_last, i_ppfifo_rdy, i_ppfifo_size,
        input  o_axi_ready, o_ppfifo_act, o_ppfifo_stb, o_ppfifo_data
    );
endinterface

// File: rtl/axis_2_ppfifo_pack.sv
// Packs PACK AXI-stream beats (LSB lane first) into one ping-pong FIFO word whose MSB is the last flag.
// Define AXIS_PPFIFO_TIMEOUT_EN to flush a partially filled buffer after TIMEOUT_CYCLES idle cycles.
module axis_2_ppfifo_pack #(
    parameter int DATA_WIDTH     = 32,
    parameter int PACK           = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    axis_2_ppfifo_pack_if.slave bus
);
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int WORD_W = DATA_WIDTH * PACK;

    if (PACK < 1 || PACK > 8) begin : g_pack_check
        $error("axis_2_ppfifo_pack: PACK must be in 1..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("axis_2_ppfifo_pack: TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

    state_t              state_q;
    logic [1:0]          act_q;
    logic                stb_q;
    logic [WORD_W:0]     data_q;
    logic [23:0]         count_q;
    logic [LANE_W-1:0]   lane_q;
    logic [WORD_W-1:0]   lanes_q;

    logic [WORD_W-1:0]   lanes_d;
    logic [23:0]         count_d;
    logic                ready;
    logic                accept;
    logic                word_done;
    logic                timed_out;

`ifdef AXIS_PPFIFO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_q;
    assign timed_out = (idle_q == TO_W'(TIMEOUT_CYCLES));
`else
    assign timed_out = 1'b0;
`endif

    assign ready     = (state_q == ACTIVE) && (count_q < bus.i_ppfifo_size) && !timed_out;
    assign accept    = ready && bus.i_axi_valid;
    assign word_done = accept && ((lane_q == LANE_W'(PACK - 1)) || bus.i_axi_last);
    assign count_d   = count_q + 24'd1;

    // Lanes above the current index are always zero, so the merged value is the finished word.
    always_comb begin
        lanes_d = lanes_q;
        lanes_d[lane_q*DATA_WIDTH +: DATA_WIDTH] = bus.i_axi_data;
    end

    // NOTE: all state here is updated with <= so every branch reads the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= '0;
            stb_q   <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            lane_q  <= '0;
            // NOTE: the lane store is reset so a packet cut by reset never leaks into the next word.
            lanes_q <= '0;
`ifdef AXIS_PPFIFO_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_ppfifo_rdy != 2'b00) begin
                        act_q   <= bus.i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
                        count_q <= '0;
                        lane_q  <= '0;
                        state_q <= ACTIVE;
`ifdef AXIS_PPFIFO_TIMEOUT_EN
                        idle_q  <= '0;
`endif
                    end
                end
                ACTIVE: begin
`ifdef AXIS_PPFIFO_TIMEOUT_EN
                    if (accept)
                        idle_q <= '0;
                    else if ((count_q != 24'd0 || lane_q != '0) && !timed_out)
                        idle_q <= idle_q + 1'b1;
`endif
                    if (word_done) begin
                        stb_q   <= 1'b1;
                        data_q  <= {bus.i_axi_last, lanes_d};
                        count_q <= count_d;
                        lane_q  <= '0;
                        lanes_q <= '0;
                        if (count_d == bus.i_ppfifo_size || bus.i_axi_last)
                            state_q <= RELEASE;
                    end else if (accept) begin
                        lanes_q <= lanes_d;
                        lane_q  <= lane_q + 1'b1;
                    end else if (count_q >= bus.i_ppfifo_size) begin
                        // Zero-sized (or shrunk) buffer: hand it straight back.
                        act_q   <= '0;
                        state_q <= RELEASE;
                    end
`ifdef AXIS_PPFIFO_TIMEOUT_EN
                    else if (timed_out) begin
                        if (lane_q != '0) begin
                            stb_q   <= 1'b1;
                            data_q  <= {1'b0, lanes_q};
                            count_q <= count_d;
                        end
                        lane_q  <= '0;
                        lanes_q <= '0;
                        state_q <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    act_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_axi_ready   = ready;
    assign bus.o_ppfifo_act  = act_q;
    assign bus.o_ppfifo_stb  = stb_q;
    assign bus.o_ppfifo_data = data_q;
endmodule

// File: tb/tb_axis_2_ppfifo_pack.sv
// Self-checking bench for axis_2_ppfifo_pack: directed and randomized packets against a queue-based packing model.
// Build with AXIS_PPFIFO_TIMEOUT_EN defined to exercise the idle flush; otherwise the buffer must be held.
module tb_axis_2_ppfifo_pack;
    localparam int DW   = 32;
    localparam int PACK = 2;
    localparam int TO   = 16;
    typedef logic [DW*PACK:0] word_t;

    logic clk = 1'b0;
    logic rst;

    axis_2_ppfifo_pack_if #(.DATA_WIDTH(DW), .PACK(PACK)) bus ();

    axis_2_ppfifo_pack #(
        .DATA_WIDTH(DW), .PACK(PACK), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Monitor: observes the DUT on the falling edge, away from the active edge.
    int         cyc = 0;
    int         last_stb_cyc = -1;
    int         drop_cyc = -1;
    int         acc_cyc = -1;
    int         act_hi = 0;
    int         rdy_hi = 0;
    logic [1:0] prev_act = 2'b00;
    word_t      obs_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.o_ppfifo_stb) begin
                obs_q.push_back(bus.o_ppfifo_data);
                last_stb_cyc <= cyc;
            end
            if (prev_act != 2'b00 && bus.o_ppfifo_act == 2'b00) drop_cyc <= cyc;
            if (bus.o_ppfifo_act != 2'b00) act_hi <= act_hi + 1;
            if (bus.o_axi_ready) rdy_hi <= rdy_hi + 1;
            if (bus.i_axi_valid && bus.o_axi_ready) acc_cyc <= cyc;
        end
        prev_act <= bus.o_ppfifo_act;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_act(input logic [1:0] exp, input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.o_ppfifo_act !== exp && n < budget);
        check(tag, bus.o_ppfifo_act, exp);
    endtask

    // Emulates the ping-pong FIFO: offers rdy, then withdraws it once the buffer is taken.
    task automatic acquire(input logic [1:0] rdy, input int size, input string tag);
        logic [1:0] exp;
        exp = rdy[0] ? 2'b01 : 2'b10;
        bus.i_ppfifo_size = 24'(size);
        bus.i_ppfifo_rdy  = rdy;
        wait_act(exp, 10, tag);
        bus.i_ppfifo_rdy = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit l, input string tag);
        int n = 0;
        bus.i_axi_valid = 1'b1;
        bus.i_axi_data  = d;
        bus.i_axi_last  = l;
        @(negedge clk);
        while (!bus.o_axi_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, bus.o_axi_ready, 1'b1);
        @(posedge clk); #1;
        bus.i_axi_valid = 1'b0;
        bus.i_axi_last  = 1'b0;
    endtask

    // Reference: beats fill lanes in order; a word closes on PACK beats or last; the
    // buffer closes on last or after size words, and later beats are not taken.
    task automatic stream(input logic [31:0] beats[$], input bit lasts[$], input int size,
                          input bit gaps, input string tag);
        word_t exp_q[$];
        word_t cur;
        int    k;
        int    used;
        bit    done;
        cur = '0; k = 0; used = 0; done = 1'b0;
        for (int i = 0; i < beats.size() && !done; i++) begin
            cur[k*DW +: DW] = beats[i];
            k++;
            used++;
            if (k == PACK || lasts[i]) begin
                cur[DW*PACK] = lasts[i];
                exp_q.push_back(cur);
                cur  = '0;
                k    = 0;
                done = lasts[i] || (exp_q.size() == size);
            end
        end
        obs_q.delete();
        for (int i = 0; i < used; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(beats[i], lasts[i], tag);
        end
        wait_act(2'b00, 20, {tag, "_release"});
        @(posedge clk); #1;
        check({tag, "_nwords"}, obs_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < obs_q.size()) check({tag, "_word"}, obs_q[i], exp_q[i]);
        check({tag, "_act_drop"}, drop_cyc, last_stb_cyc + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] beats[$];
        bit          lasts[$];
        int          a0;
        int          r0;
        int          delta;

        rst               = 1'b1;
        bus.i_axi_valid   = 1'b0;
        bus.i_axi_data    = '0;
        bus.i_axi_last    = 1'b0;
        bus.i_ppfifo_rdy  = 2'b00;
        bus.i_ppfifo_size = 24'd4;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.o_axi_ready, 1'b0);
        check("rst_act", bus.o_ppfifo_act, 2'b00);
        check("rst_stb", bus.o_ppfifo_stb, 1'b0);
        check("rst_data", bus.o_ppfifo_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("idle_act", bus.o_ppfifo_act, 2'b00);

        // Both buffers ready: buffer 0 wins, 8 beats fill 4 words, then buffer 1 is taken
        acquire(2'b11, 4, "fill_act01");
        beats.delete(); lasts.delete();
        for (int i = 1; i <= 8; i++) begin
            beats.push_back(32'(i));
            lasts.push_back(1'b0);
        end
        stream(beats, lasts, 4, 1'b0, "fill");
        acquire(2'b10, 4, "fill_act10");

        // Early release on last, partial word zero-filled
        beats.delete(); lasts.delete();
        for (int i = 1; i <= 3; i++) begin
            beats.push_back(32'(i));
            lasts.push_back(i == 3);
        end
        stream(beats, lasts, 4, 1'b0, "last");

        // Randomized packets
        for (int t = 0; t < 8; t++) begin
            int         sz;
            int         nb;
            bit         has_last;
            logic [1:0] rdy;
            sz       = $urandom_range(1, 4);
            nb       = $urandom_range(1, 2 * sz + 2);
            has_last = 1'($urandom_range(0, 1));
            if (!has_last && nb < PACK * sz) has_last = 1'b1;
            beats.delete(); lasts.delete();
            for (int i = 0; i < nb; i++) begin
                beats.push_back($urandom);
                lasts.push_back(has_last && (i == nb - 1));
            end
            case ($urandom_range(0, 2))
                0:       rdy = 2'b01;
                1:       rdy = 2'b10;
                default: rdy = 2'b11;
            endcase
            acquire(rdy, sz, "rand_act");
            stream(beats, lasts, sz, 1'b1, "rand");
        end

        // Zero-sized buffer: one cycle of ownership, never ready, no strobe
        obs_q.delete();
        a0 = act_hi;
        r0 = rdy_hi;
        acquire(2'b01, 0, "size0_act");
        repeat (6) @(posedge clk); #1;
        check("size0_act_cycles", act_hi - a0, 1);
        check("size0_ready_cycles", rdy_hi - r0, 0);
        check("size0_no_strobe", obs_q.size(), 0);

        // Reset mid-packet discards the partial word
        acquire(2'b10, 4, "midrst_act");
        obs_q.delete();
        send_beat(32'h55, 1'b0, "midrst");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_act_after", bus.o_ppfifo_act, 2'b00);
        repeat (4) @(negedge clk);
        check("midrst_no_strobe", obs_q.size(), 0);
        @(posedge clk); #1;
        acquire(2'b01, 4, "postrst_act");
        beats.delete(); lasts.delete();
        beats.push_back(32'h77);
        lasts.push_back(1'b1);
        stream(beats, lasts, 4, 1'b0, "postrst");

        // Idle buffer with a single partial beat
        acquire(2'b01, 4, "idle_act");
        obs_q.delete();
        send_beat(32'hA, 1'b0, "idle");
        repeat (40) @(posedge clk); #1;
`ifdef AXIS_PPFIFO_TIMEOUT_EN
        delta = last_stb_cyc - acc_cyc;
        check("timeout_nwords", obs_q.size(), 1);
        check("timeout_word", (obs_q.size() > 0) ? obs_q[0] : '0, {1'b0, 32'h0, 32'hA});
        check("timeout_delay_ok", (delta >= 17 && delta <= 19), 1'b1);
        check("timeout_act", bus.o_ppfifo_act, 2'b00);
        check("timeout_act_drop", drop_cyc, last_stb_cyc + 1);
`else
        delta = 0;
        check("hold_no_strobe", obs_q.size(), 0);
        check("hold_act", bus.o_ppfifo_act, 2'b01);
        check("hold_ready", bus.o_axi_ready, 1'b1);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("final_act", bus.o_ppfifo_act, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_2_ppfifo_pack.md
AXIS_2_PPFIFO_PACK -- requirements
Module: axis_2_ppfifo_pack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXI stream beat width in bits.
REQ-002 SHALL have parameter PACK, default 2: AXI beats packed per ping-pong FIFO word; legal range 1..8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: idle-flush limit in cycles; only used with the macro in REQ-021.
REQ-004 SHALL have port clk  input  1  clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_axi_valid  input  1  AXI stream beat valid.
REQ-007 SHALL have port o_axi_ready  output  1  AXI stream ready.
REQ-008 SHALL have port i_axi_data  input  DATA_WIDTH  AXI stream beat data.
REQ-009 SHALL have port i_axi_last  input  1  AXI stream end of packet.
REQ-010 SHALL have port i_ppfifo_rdy  input  2  per-buffer ready from the ping-pong FIFO.
REQ-011 SHALL have port o_ppfifo_act  output  2  one-hot buffer ownership.
REQ-012 SHALL have port i_ppfifo_size  input  24  buffer capacity in packed words.
REQ-013 SHALL have port o_ppfifo_stb  output  1  single-cycle write strobe.
REQ-014 SHALL have port o_ppfifo_data  output  DATA_WIDTH*PACK+1  packed word; MSB is the last flag.

Function
REQ-015 SHALL implement states IDLE, ACTIVE and RELEASE; IDLE with i_ppfifo_rdy != 0 SHALL set the matching o_ppfifo_act bit (bit 0 wins when both are ready), clear the word count and lane index, and enter ACTIVE on the same edge.
REQ-016 SHALL drive o_axi_ready combinationally high only when the state is ACTIVE and the word count is less than i_ppfifo_size; a beat is accepted on any cycle with i_axi_valid and o_axi_ready both high, and back-to-back acceptance SHALL sustain one beat per cycle.
REQ-017 SHALL store each accepted beat in lane[lane index], with lane 0 at bits [DATA_WIDTH-1:0] (LSB first), then increment the lane index.
REQ-018 SHALL, when an accepted beat fills lane PACK-1 or carries i_axi_last, assert o_ppfifo_stb for exactly one cycle on the next cycle; at that point o_ppfifo_data SHALL hold the assembled word with unfilled lanes zero and MSB = i_axi_last, the word count SHALL increment and the lane index SHALL clear.
REQ-019 SHALL move from ACTIVE to RELEASE on the edge that completes a word when the new count equals i_ppfifo_size or that word carried last; RELEASE SHALL clear o_ppfifo_act (one cycle after the final strobe) and return to IDLE.
REQ-020 SHALL, when i_ppfifo_size = 0, go ACTIVE then RELEASE with no strobe: o_ppfifo_act is high for exactly one cycle and o_axi_ready stays low.

Configuration
REQ-021 SHALL, with macro AXIS_PPFIFO_TIMEOUT_EN defined, count consecutive ACTIVE cycles with no accepted beat while count > 0 or lane > 0; the counter SHALL clear on any accepted beat or activation.
REQ-022 SHALL, when that counter reaches TIMEOUT_CYCLES, deassert o_axi_ready; if lane > 0 it SHALL strobe the partial word with MSB = 0; it SHALL then enter RELEASE.
REQ-023 SHALL, without AXIS_PPFIFO_TIMEOUT_EN, omit the timeout logic, hold a partially filled buffer indefinitely, and ignore TIMEOUT_CYCLES.

Reset
REQ-024 SHALL, on rst, set the state to IDLE and clear o_ppfifo_act, o_ppfifo_stb, o_ppfifo_data, the word count, the lane index, the lane registers and the timeout counter; o_axi_ready SHALL therefore be 0.
REQ-025 SHALL, on rst asserted mid-packet, discard partial lanes without a strobe and drop o_ppfifo_act on that edge.

Verification (DATA_WIDTH=32, PACK=2, size=4 unless stated)
REQ-026 Drive rdy=11 with 8 beats 0x1..0x8, no last -> act=01, 4 strobes 0_00000002_00000001..0_00000008_00000007, act drops one cycle after the 4th strobe, then act=10 is acquired.
REQ-027 Send 3 beats 0x1, 0x2, 0x3 with last on the 3rd -> strobes 0_00000002_00000001 and 1_00000000_00000003, then act=00 and the buffer is released early.
REQ-028 Set size=0 with rdy=01 -> act=01 for one cycle, no strobe, o_axi_ready never high.
REQ-029 Set rdy=10 only -> act=10; assert rst after 1 beat -> no strobe and act=00 after the reset edge.
REQ-030 With the macro defined and TIMEOUT_CYCLES=16, send 1 beat 0xA then idle -> after 16 idle cycles a strobe of 0_00000000_0000000A, then act drops; without the macro -> no strobe and act held.
